// File: rtl/output_seq_pkg.sv
// Shared types and constants for the output drain sequencer.
// The control-strobe decode lives here so that the FSM and any checker agree on it.
package output_seq_pkg;

    localparam int OUT_SEQ_IN_WIDTH  = 512;
    localparam int OUT_SEQ_OUT_WIDTH = 64;
    localparam int OUT_SEQ_NUM_BEATS = OUT_SEQ_IN_WIDTH / OUT_SEQ_OUT_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        SHIFT   = 3'd4,
        DONE    = 3'd5
    } out_seq_state_t;

    typedef struct packed {
        logic start_ready;
        logic load;
        logic shift;
        logic dest_valid;
        logic busy;
        logic done;
    } out_seq_ctrl_t;

    // Moore decode of the datapath strobes for a given state.
    function automatic out_seq_ctrl_t decode_ctrl(input out_seq_state_t st);
        out_seq_ctrl_t c;
        c = '0;
        case (st)
            IDLE:    c.start_ready = 1'b1;
            CAPTURE: c.busy        = 1'b1;
            LOAD: begin
                c.busy = 1'b1;
                c.load = 1'b1;
            end
            SEND: begin
                c.busy       = 1'b1;
                c.dest_valid = 1'b1;
            end
            SHIFT: begin
                c.busy  = 1'b1;
                c.shift = 1'b1;
            end
            DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: c.start_ready = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/output_seq_beat_counter.sv
// Beat index register for the drain sequence: synchronous clear, saturating increment,
// and a flag marking the final beat of a result.
module output_seq_beat_counter #(
    parameter  int NUM_BEATS = 8,
    localparam int BEAT_W    = $clog2(NUM_BEATS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [BEAT_W-1:0] count,
    output logic              last
);

    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(NUM_BEATS - 1);

    logic [BEAT_W-1:0] count_r;

    // Clear wins over increment; the index holds at the final beat rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != LAST_IDX)) begin
            count_r <= count_r + {{(BEAT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == LAST_IDX);

endmodule

// File: rtl/output_sequencer.sv
// Output drain controller: capture, feeder load, then NUM_BEATS ready/valid beats with shifts between.
// Optional stall watchdog compiled in with OUTPUT_SEQ_WATCHDOG_EN.
module output_sequencer
    import output_seq_pkg::*;
#(
    parameter  int IN_WIDTH       = OUT_SEQ_IN_WIDTH,
    parameter  int OUT_WIDTH      = OUT_SEQ_OUT_WIDTH,
`ifdef OUTPUT_SEQ_WATCHDOG_EN
    parameter  int TIMEOUT_CYCLES = 1024,
`endif
    localparam int NUM_BEATS      = IN_WIDTH / OUT_WIDTH,
    localparam int BEAT_W         = $clog2(NUM_BEATS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              start_ready,
    input  logic              flush,
    input  logic              src_ready,
    output logic              load,
    output logic              shift,
    output logic              dest_valid,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    out_seq_state_t state_r;
    out_seq_state_t state_nx_s;
    out_seq_ctrl_t  ctrl_r;
    logic           beat_clr_s;
    logic           beat_inc_s;
    logic           beat_last_s;
    logic           timeout_hit_s;
    logic           timeout_err_r;

    assign beat_clr_s = (state_r == LOAD) || flush;
    assign beat_inc_s = (state_r == SHIFT);

    output_seq_beat_counter #(
        .NUM_BEATS (NUM_BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .clear (beat_clr_s),
        .inc   (beat_inc_s),
        .count (beat_idx),
        .last  (beat_last_s)
    );

`ifdef OUTPUT_SEQ_WATCHDOG_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] stall_r;

    assign timeout_hit_s = (state_r == SEND) && !src_ready &&
                           (stall_r == STALL_W'(TIMEOUT_CYCLES - 1));

    // Stall count is zero outside SEND, so every entry to SEND starts a fresh window.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r       <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r != SEND) begin
                stall_r <= '0;
            end else if (!src_ready) begin
                stall_r <= stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
            end else begin
                stall_r <= stall_r;
            end
            if (timeout_hit_s && !flush) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err_r = 1'b0;
`endif

    // Next-state selection; flush outranks the watchdog, a handshake and a new start.
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = IDLE;
        end else if (timeout_hit_s) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nx_s = CAPTURE;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                CAPTURE: state_nx_s = LOAD;
                LOAD:    state_nx_s = SEND;
                SEND: begin
                    if (src_ready) begin
                        if (beat_last_s) begin
                            state_nx_s = DONE;
                        end else begin
                            state_nx_s = SHIFT;
                        end
                    end else begin
                        state_nx_s = SEND;
                    end
                end
                SHIFT:   state_nx_s = SEND;
                DONE:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State register with strobes pre-decoded from the next state so they leave a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ctrl_r  <= decode_ctrl(IDLE);
        end else begin
            state_r <= state_nx_s;
            ctrl_r  <= decode_ctrl(state_nx_s);
        end
    end

    assign start_ready = ctrl_r.start_ready;
    assign load        = ctrl_r.load;
    assign shift       = ctrl_r.shift;
    assign dest_valid  = ctrl_r.dest_valid;
    assign busy        = ctrl_r.busy;
    assign done        = ctrl_r.done;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_output_sequencer.sv
// Self-checking bench for output_sequencer: progress-counter reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_output_sequencer;

    localparam int NB = 8;
`ifdef OUTPUT_SEQ_WATCHDOG_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       start_ready;
    logic       flush;
    logic       src_ready;
    logic       load;
    logic       shift;
    logic       dest_valid;
    logic [2:0] beat_idx;
    logic       busy;
    logic       done;
    logic       timeout_err;

`ifdef OUTPUT_SEQ_WATCHDOG_EN
    output_sequencer #(.TIMEOUT_CYCLES(TB_TO)) dut (
`else
    output_sequencer dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_ready (start_ready),
        .flush       (flush),
        .src_ready   (src_ready),
        .load        (load),
        .shift       (shift),
        .dest_valid  (dest_valid),
        .beat_idx    (beat_idx),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is a walk through progress positions.
    // pos 0 capture, 1 load, 2,4,..,2*NB sends, 3,5,..,2*NB-1 shifts, 2*NB+1 done.
    bit m_busy = 1'b0;
    int m_pos  = 0;
    int m_beat = 0;
    bit m_err  = 1'b0;
    int m_stall = 0;
    bit m_snd;
    bit m_shf;

    function automatic bit is_send(input int p);
        return (p >= 2) && (p <= 2*NB) && (p % 2 == 0);
    endfunction

    function automatic bit is_shift(input int p);
        return (p >= 3) && (p <= 2*NB - 1) && (p % 2 == 1);
    endfunction

    always @(posedge clk) begin
        m_snd = m_busy && is_send(m_pos);
        m_shf = m_busy && is_shift(m_pos);
        if (reset) begin
            m_busy = 1'b0; m_beat = 0; m_err = 1'b0; m_stall = 0;
        end else if (flush) begin
            m_busy = 1'b0; m_beat = 0; m_stall = 0;
        end else if (!m_busy) begin
            m_stall = 0;
            if (start) begin
                m_busy = 1'b1; m_pos = 0;
            end
        end else if (TB_TO > 0 && m_snd && !src_ready && m_stall == TB_TO - 1) begin
            m_err = 1'b1; m_busy = 1'b0; m_stall = 0;
        end else begin
            if (m_pos == 1) m_beat = 0;
            if (m_shf) m_beat = m_beat + 1;
            if (m_snd && !src_ready) m_stall = m_stall + 1;
            else m_stall = 0;
            if (m_snd && !src_ready) m_pos = m_pos;
            else if (m_pos == 2*NB + 1) m_busy = 1'b0;
            else m_pos = m_pos + 1;
        end
    end

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("start_ready", start_ready, !m_busy);
            chk("busy",        busy,        m_busy);
            chk("load",        load,        m_busy && m_pos == 1);
            chk("dest_valid",  dest_valid,  m_busy && is_send(m_pos));
            chk("shift",       shift,       m_busy && is_shift(m_pos));
            chk("done",        done,        m_busy && m_pos == 2*NB + 1);
            chk("beat_idx",    beat_idx,    m_beat);
            chk("timeout_err", timeout_err, m_err);
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (start_ready) begin ok = 1'b1; break; end
        end
        chk("wait_idle", ok, 1'b1);
    endtask

    // kind 0: a SEND cycle of beat b; kind 1: a SHIFT cycle out of beat b
    task automatic wait_beat(input int kind, input int b);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (((kind == 0) ? dest_valid : shift) && beat_idx == 3'(b)) begin ok = 1'b1; break; end
        end
        chk("wait_beat", ok, 1'b1);
    endtask

    // One job from a single start pulse; cycle 1 is the first cycle after acceptance.
    task automatic drain(input int sb, input int sl, output int lc, output int dc,
                         output int ns, output int nv, output int nb);
        int st = 0;
        lc = -1; dc = -1; ns = 0; nv = 0; nb = 0;
        @(negedge clk);
        start = 1'b1; src_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (load) lc = c;
            if (done) dc = c;
            if (shift) ns++;
            if (dest_valid) nv++;
            if (busy) nb++;
            if (dest_valid && beat_idx == 3'(sb) && st < sl) begin src_ready = 1'b0; st++; end
            else src_ready = 1'b1;
            if (dc >= 0) break;
        end
    endtask

    int lc, dc, ns, nv, nb, nd;
    bit got;

    initial begin
        clk = 1'b0; reset = 1'b1; start = 1'b0; flush = 1'b0; src_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_beat", beat_idx, 3'd0);
        reset = 1'b0;

        // nominal drain
        wait_idle();
        drain(-1, 0, lc, dc, ns, nv, nb);
        chk("nom_load_cyc", lc, 2);
        chk("nom_done_cyc", dc, 18);
        chk("nom_shifts", ns, 7);
        chk("nom_valids", nv, 8);
        chk("nom_busy_cyc", nb, 18);

        // backpressure on beat 4
        wait_idle();
        drain(4, 3, lc, dc, ns, nv, nb);
        chk("bp_done_cyc", dc, 21);
        chk("bp_shifts", ns, 7);
        chk("bp_valids", nv, 11);

        // start while busy is ignored; a held start is taken once idle
        wait_idle();
        @(negedge clk); start = 1'b1; src_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_beat(0, 2);
        start = 1'b1;
        chk("rej_start_ready", start_ready, 1'b0);
        nd = 0; got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (load) begin got = 1'b1; start = 1'b0; break; end
        end
        chk("rej_accepted", got, 1'b1);
        chk("rej_dones", nd, 1);
        wait_idle();

        // flush beats a same-cycle handshake on the last beat
        @(negedge clk); start = 1'b1; src_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_beat(0, 7);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("fl_done", done, 1'b0);
        chk("fl_beat", beat_idx, 3'd0);
        chk("fl_start_ready", start_ready, 1'b1);

        // reset during the shift out of beat 3, then a clean job
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_beat(1, 3);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rm_start_ready", start_ready, 1'b1);
        chk("rm_shift", shift, 1'b0);
        chk("rm_busy", busy, 1'b0);
        chk("rm_beat", beat_idx, 3'd0);
        drain(-1, 0, lc, dc, ns, nv, nb);
        chk("rm_done_cyc", dc, 18);

`ifdef OUTPUT_SEQ_WATCHDOG_EN
        // watchdog: stall forever on beat 0
        wait_idle();
        @(negedge clk); start = 1'b1; src_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        nv = 0; got = 1'b0; nd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (timeout_err) begin got = 1'b1; break; end
            if (dest_valid) nv++;
        end
        chk("wd_err", got, 1'b1);
        chk("wd_send_cycles", nv, TB_TO);
        chk("wd_idle", busy, 1'b0);
        chk("wd_dones", nd, 0);
        repeat (5) @(negedge clk);
        chk("wd_sticky", timeout_err, 1'b1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("wd_cleared", timeout_err, 1'b0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 4) == 0);
            src_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) < 2);
            reset     = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0; reset = 1'b0; src_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
